// File: rtl/param_fifo.sv
// Synchronous FIFO with an arbitrary (non power-of-two) depth, occupancy-decoded status flags
// and either a registered read port or a first-word-fall-through output.
module param_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   data_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          wr_ack_reg, overflow_reg, underflow_reg;
  logic          wr_accept, rd_accept;

  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= CW'(AF_LEVEL));
  assign almost_empty = (count_reg <= CW'(AE_LEVEL));
  assign data_count   = count_reg;
  assign wr_ack       = wr_ack_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Full blocks only the write and empty blocks only the read, so a simultaneous
  // request at either boundary still lets the other side proceed.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    // Explicit wrap compare keeps the pointers correct for non power-of-two depths.
    if (wr_accept) begin
      wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
    end
    if (rd_accept) begin
      rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      wr_ack_reg    <= wr_accept;
      overflow_reg  <= wr_en & full;
      underflow_reg <= rd_en & empty;
    end
  end

  // Storage is never cleared; reset only discards entries by rewinding the pointers.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr_reg];
    end else begin : g_std
      logic [WIDTH-1:0] data_out_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_out_reg <= '0;
        end else if (rd_accept) begin
          data_out_reg <= mem[rd_ptr_reg];
        end
      end

      assign data_out = data_out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a registered-read DEPTH=8 instance and a FWFT DEPTH=5 instance,
// each driven through directed and random steps and compared with a queue model.
module tb_param_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, wr_en_a, rd_en_a;
  logic [15:0] din_a, dout_a;
  logic        full_a, empty_a, af_a, ae_a, ack_a, ovf_a, udf_a;
  logic [3:0]  cnt_a;

  logic        rst_b, wr_en_b, rd_en_b;
  logic [15:0] din_b, dout_b;
  logic        full_b, empty_b, af_b, ae_b, ack_b, ovf_b, udf_b;
  logic [2:0]  cnt_b;

  param_fifo #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .data_in(din_a), .rd_en(rd_en_a),
    .data_out(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .wr_ack(ack_a), .overflow(ovf_a), .underflow(udf_a),
    .data_count(cnt_a)
  );

  param_fifo #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .data_in(din_b), .rd_en(rd_en_b),
    .data_out(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .wr_ack(ack_b), .overflow(ovf_b), .underflow(udf_b),
    .data_count(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] exp_dout_a = '0;
  logic        exp_ack_a = 1'b0, exp_ovf_a = 1'b0, exp_udf_a = 1'b0;
  logic        exp_ack_b = 1'b0, exp_ovf_b = 1'b0, exp_udf_b = 1'b0;

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
    end
  endtask

  function automatic logic [15:0] head_b();
    return (q_b.size() > 0) ? q_b[0] : 16'h0000;
  endfunction

  task automatic check_a(input string tag);
    int n = q_a.size();
    chk(tag, "count", 32'(cnt_a), 32'(n));
    chk(tag, "full", 32'(full_a), 32'(n == 8));
    chk(tag, "empty", 32'(empty_a), 32'(n == 0));
    chk(tag, "almost_full", 32'(af_a), 32'(n >= 6));
    chk(tag, "almost_empty", 32'(ae_a), 32'(n <= 1));
    chk(tag, "wr_ack", 32'(ack_a), 32'(exp_ack_a));
    chk(tag, "overflow", 32'(ovf_a), 32'(exp_ovf_a));
    chk(tag, "underflow", 32'(udf_a), 32'(exp_udf_a));
    chk(tag, "data_out", 32'(dout_a), 32'(exp_dout_a));
  endtask

  task automatic check_b(input string tag);
    int n = q_b.size();
    chk(tag, "count", 32'(cnt_b), 32'(n));
    chk(tag, "full", 32'(full_b), 32'(n == 5));
    chk(tag, "empty", 32'(empty_b), 32'(n == 0));
    chk(tag, "almost_full", 32'(af_b), 32'(n >= 3));
    chk(tag, "almost_empty", 32'(ae_b), 32'(n <= 1));
    chk(tag, "wr_ack", 32'(ack_b), 32'(exp_ack_b));
    chk(tag, "overflow", 32'(ovf_b), 32'(exp_ovf_b));
    chk(tag, "underflow", 32'(udf_b), 32'(exp_udf_b));
    chk(tag, "data_out", 32'(dout_b), 32'(head_b()));
  endtask

  // One clock of DUT A: drive, confirm data_out holds before the edge, advance model, check.
  task automatic step_a(input string tag, input bit rs, input bit wr, input logic [15:0] d,
                        input bit rd);
    int n;
    rst_a = rs; wr_en_a = wr; din_a = d; rd_en_a = rd;
    #1;
    if (!rs) chk(tag, "pre_edge_data_out", 32'(dout_a), 32'(exp_dout_a));
    @(posedge clk);
    n = q_a.size();
    if (rs) begin
      q_a.delete();
      exp_dout_a = '0;
      exp_ack_a = 1'b0; exp_ovf_a = 1'b0; exp_udf_a = 1'b0;
    end else begin
      exp_ack_a = wr && (n < 8);
      exp_ovf_a = wr && (n == 8);
      exp_udf_a = rd && (n == 0);
      if (rd && n > 0) exp_dout_a = q_a.pop_front();
      if (exp_ack_a) q_a.push_back(d);
    end
    #1;
    $display("A %-10s rst=%0b wr=%0b din=%04h rd=%0b -> count=%0d dout=%04h ack=%0b ovf=%0b udf=%0b",
             tag, rs, wr, d, rd, cnt_a, dout_a, ack_a, ovf_a, udf_a);
    check_a(tag);
  endtask

  // One clock of DUT B; the pre-edge check also proves a write into empty does not bypass.
  task automatic step_b(input string tag, input bit rs, input bit wr, input logic [15:0] d,
                        input bit rd);
    int n;
    rst_b = rs; wr_en_b = wr; din_b = d; rd_en_b = rd;
    #1;
    if (!rs) chk(tag, "pre_edge_data_out", 32'(dout_b), 32'(head_b()));
    @(posedge clk);
    n = q_b.size();
    if (rs) begin
      q_b.delete();
      exp_ack_b = 1'b0; exp_ovf_b = 1'b0; exp_udf_b = 1'b0;
    end else begin
      exp_ack_b = wr && (n < 5);
      exp_ovf_b = wr && (n == 5);
      exp_udf_b = rd && (n == 0);
      if (rd && n > 0) void'(q_b.pop_front());
      if (exp_ack_b) q_b.push_back(d);
    end
    #1;
    $display("B %-10s rst=%0b wr=%0b din=%04h rd=%0b -> count=%0d dout=%04h ack=%0b ovf=%0b udf=%0b",
             tag, rs, wr, d, rd, cnt_b, dout_b, ack_b, ovf_b, udf_b);
    check_b(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, br;
    rst_a = 1'b1; wr_en_a = 1'b0; rd_en_a = 1'b0; din_a = '0;
    rst_b = 1'b1; wr_en_b = 1'b0; rd_en_b = 1'b0; din_b = '0;

    // Registered-read instance, DEPTH=8
    step_a("reset", 1, 0, 16'h0, 0);
    step_a("reset", 1, 0, 16'h0, 0);
    for (int i = 1; i <= 8; i++) step_a("fill", 0, 1, 16'(i), 0);
    step_a("overflow", 0, 1, 16'h0009, 0);
    for (int i = 1; i <= 8; i++) step_a("drain", 0, 0, 16'h0, 1);
    step_a("underflow", 0, 0, 16'h0, 1);
    step_a("rw_empty", 0, 1, 16'h00A0, 1);
    for (int i = 1; i <= 3; i++) step_a("to4", 0, 1, 16'(16'h00B0 + i), 0);
    step_a("rw_at4", 0, 1, 16'h00C0, 1);
    for (int i = 1; i <= 4; i++) step_a("to8", 0, 1, 16'(16'h00D0 + i), 0);
    step_a("rw_full", 0, 1, 16'h00E0, 1);
    step_a("to5", 0, 0, 16'h0, 1);
    step_a("to5", 0, 0, 16'h0, 1);
    step_a("rst_wr", 1, 1, 16'hDEAD, 0);
    step_a("post_wr", 0, 1, 16'h5A5A, 0);
    step_a("post_rd", 0, 0, 16'h0, 1);
    step_a("post_rd2", 0, 0, 16'h0, 1);
    for (int i = 0; i < 400; i++) begin
      bw = ((i / 40) % 2 == 0) ? 75 : 25;
      br = 100 - bw;
      step_a("rand", $urandom_range(0, 79) == 0, $urandom_range(0, 99) < bw,
             16'($urandom), $urandom_range(0, 99) < br);
    end

    // FWFT instance, DEPTH=5
    step_b("reset", 1, 0, 16'h0, 0);
    step_b("reset", 1, 0, 16'h0, 0);
    for (int i = 0; i < 12; i++) begin
      step_b("pair_wr", 0, 1, 16'(16'h1000 + i), 0);
      step_b("pair_rd", 0, 0, 16'h0, 1);
    end
    step_b("lead_wr", 0, 1, 16'h2000, 0);
    for (int i = 1; i <= 12; i++) step_b("pair_rw", 0, 1, 16'(16'h2000 + i), 1);
    for (int i = 0; i < 5; i++) step_b("fill", 0, 1, 16'(16'h3000 + i), 0);
    step_b("overflow", 0, 1, 16'h3FFF, 0);
    step_b("rw_full", 0, 1, 16'h3EEE, 1);
    step_b("rst_wr", 1, 1, 16'hBEEF, 0);
    step_b("rw_empty", 0, 1, 16'h4444, 1);
    step_b("post_rd", 0, 0, 16'h0, 1);
    step_b("underflow", 0, 0, 16'h0, 1);
    for (int i = 0; i < 400; i++) begin
      bw = ((i / 30) % 2 == 0) ? 70 : 30;
      br = 100 - bw;
      step_b("rand", $urandom_range(0, 79) == 0, $urandom_range(0, 99) < bw,
             16'($urandom), $urandom_range(0, 99) < br);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, >= 1.
REQ-002 Parameter DEPTH, default 8: number of storage entries, >= 2; need not be a power of two.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold in entries, 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty threshold in entries, 1..DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 = standard registered read; 1 = first-word-fall-through.
REQ-006 Design uses one clock, clk. Reset rst is synchronous and active-high.
REQ-007 Ports (name, direction, width, meaning):
- clk, in, 1: clock; all state changes on its rising edge.
- rst, in, 1: synchronous active-high reset.
- wr_en, in, 1: write request.
- data_in, in, WIDTH: write data.
- rd_en, in, 1: read request.
- data_out, out, WIDTH: read data.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= AF_LEVEL.
- almost_empty, out, 1: count <= AE_LEVEL.
- wr_ack, out, 1: registered; the previous cycle's write was accepted.
- overflow, out, 1: registered; the previous cycle's write was rejected because the FIFO was full.
- underflow, out, 1: registered; the previous cycle's read was rejected because the FIFO was empty.
- data_count, out, $clog2(DEPTH+1): current occupancy.

Function
REQ-008 Write acceptance: a write is accepted when wr_en=1 and full=0. On acceptance, data_in is stored at wr_ptr.
REQ-009 Read acceptance: a read is accepted when rd_en=1 and empty=0.
REQ-010 Pointer wrap: wr_ptr and rd_ptr each advance by 1 per accepted operation and wrap from DEPTH-1 to 0. This holds for any DEPTH, not only powers of two.
REQ-011 Count update per cycle:
- write accepted only: data_count +1.
- read accepted only: data_count -1.
- both accepted, or neither: data_count unchanged.
REQ-012 Full with wr_en=1 and rd_en=1: the read is accepted and the write is rejected. Next cycle: overflow=1, wr_ack=0, data_count = DEPTH-1.
REQ-013 Empty with wr_en=1 and rd_en=1: the write is accepted and the read is rejected. Next cycle: underflow=1, wr_ack=1, data_count = 1.
REQ-014 Status flags full, empty, almost_full and almost_empty are combinational decodes of data_count. They update in the same cycle data_count changes.
REQ-015 wr_ack, overflow and underflow are single-cycle pulses, valid exactly one cycle after the request. Each is 0 in any cycle where its condition did not occur on the previous edge.
REQ-016 FWFT=0: data_out is registered. It takes mem[rd_ptr] on the edge of an accepted read (1-cycle latency). It holds its value otherwise, including on a rejected read.
REQ-017 FWFT=1: data_out = mem[rd_ptr] whenever empty=0; an accepted read pops the current head. data_out is 0 while empty=1.
REQ-018 FWFT=1 write to an empty FIFO: data_out shows the written word in the cycle after the write edge. Data never bypasses to the output in the write cycle itself.
REQ-019 Data order is strictly first-in first-out; no entry is duplicated, dropped or reordered across pointer wrap.
REQ-020 data_count never exceeds DEPTH and never goes below 0 under any input sequence.

Reset
REQ-021 On a clk edge with rst=1, the following clear: wr_ptr, rd_ptr, data_count, wr_ack, overflow, underflow, and data_out (set to 0).
REQ-022 During and after reset, empty=1, full=0, almost_empty=1, almost_full=0.
REQ-023 rst has priority over wr_en and rd_en in the same cycle: no write is stored and no read pops.
REQ-024 Reset mid-operation discards all stored entries logically. Memory contents are not cleared and are never visible after reset.

Verification
REQ-025 The bench SHALL cover at least these directed scenarios (WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1 unless stated):
- Fill: 8 writes 0x0001..0x0008 -> wr_ack=1 on each; almost_full at count 6; full at count 8. A 9th write -> overflow=1, wr_ack=0, count stays 8.
- Drain (FWFT=0): 8 reads -> data_out = 0x0001..0x0008, each one cycle after its read edge. A 9th read -> underflow=1, data_out holds 0x0008, empty=1.
- Simultaneous read and write at count 4 -> count stays 4, wr_ack=1, head advances. At full -> REQ-012. At empty -> REQ-013.
- DEPTH=5, FWFT=1: 12 interleaved write/read pairs with ptr wrap -> output sequence equals input sequence; data_out valid the cycle after the write into empty.
- Reset at count 5 with wr_en=1 -> next cycle count=0, empty=1, data_out=0, wr_ack=0. A subsequent write/read returns the new word, not stale data.
